// File: rtl/dma_channel_arbiter_pkg.sv
// Shared types and defaults for the DMA channel arbiter: FSM state encoding
// and the controller-matched field widths.
package dma_channel_arbiter_pkg;

  localparam int ADD_LEN_DEF  = 16;
  localparam int DATA_LEN_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_BUSY    = 3'd2,
    ST_ABORT   = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  // States in which the owner's request fields are presented to the controller.
  function automatic logic holds_bus(input state_t s);
    return (s == ST_ISSUE) || (s == ST_BUSY);
  endfunction

endpackage

// File: rtl/dma_channel_arbiter_if.sv
// Device-side port bundle of the dma_controller as seen by the arbiter
// (master) and by the controller itself (slave).
interface dma_channel_arbiter_if
  import dma_channel_arbiter_pkg::*;
#(
  parameter int ADD_LEN  = ADD_LEN_DEF,
  parameter int DATA_LEN = DATA_LEN_DEF
);

  // Handshake: dma_dev_ack is the owner's data-valid/ready toward the controller,
  // dma_ack_in is the controller's acknowledge; a word moves in any cycle where
  // both are high, and neither side may depend on the other combinationally.
  logic                dma_rqst;
  logic                dma_rd_wr;
  logic [ADD_LEN-1:0]  dma_num_words;
  logic [ADD_LEN:0]    dma_start_addr;
  logic                dma_dev_ack;
  logic [DATA_LEN-1:0] dma_dev_in;
  logic                dma_rst;
  logic                dma_ack_in;
  logic                dma_end_flag;
  logic [DATA_LEN-1:0] dma_dev_out;

  modport master (
    output dma_rqst, dma_rd_wr, dma_num_words, dma_start_addr,
           dma_dev_ack, dma_dev_in, dma_rst,
    input  dma_ack_in, dma_end_flag, dma_dev_out
  );

  modport slave (
    input  dma_rqst, dma_rd_wr, dma_num_words, dma_start_addr,
           dma_dev_ack, dma_dev_in, dma_rst,
    output dma_ack_in, dma_end_flag, dma_dev_out
  );

endinterface

// File: rtl/dma_channel_arbiter_rr_picker.sv
// Combinational round-robin picker: scans the request vector starting one
// slot after last_owner (rotate + priority encode) and returns the winner.
module dma_channel_arbiter_rr_picker #(
  parameter int N_DEV = 4,
  parameter int IDX_W = $clog2(N_DEV)
) (
  input  logic [N_DEV-1:0] req,
  input  logic [IDX_W-1:0] last_owner,
  output logic [N_DEV-1:0] grant,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // One extra bit so last_owner+1+i never wraps before the modulo fold.
  localparam int SW = IDX_W + 1;

  logic [SW-1:0] slot;

  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    slot  = '0;
    for (int i = 0; i < N_DEV; i++) begin
      slot = SW'(last_owner) + SW'(i) + SW'(1);
      if (slot >= SW'(N_DEV)) slot = slot - SW'(N_DEV);
      if (!valid && req[slot[IDX_W-1:0]]) begin
        valid = 1'b1;
        idx   = slot[IDX_W-1:0];
      end
    end
    if (valid) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/dma_channel_arbiter.sv
// Shares one dma_controller between N_DEV devices: round-robin grant, field and
// handshake steering to the owner, end/abort pulses and an ownership watchdog.
module dma_channel_arbiter
  import dma_channel_arbiter_pkg::*;
#(
  parameter int N_DEV    = 4,
  parameter int ADD_LEN  = ADD_LEN_DEF,
  parameter int DATA_LEN = DATA_LEN_DEF,
  parameter int TIMEOUT  = 4096,
  parameter int TO_W     = 13
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_DEV-1:0]            dev_rqst,
  input  logic [N_DEV-1:0]            dev_rd_wr,
  input  logic [N_DEV*ADD_LEN-1:0]    dev_num_words,
  input  logic [N_DEV*(ADD_LEN+1)-1:0] dev_start_addr,
  input  logic [N_DEV-1:0]            dev_ack_in,
  input  logic [N_DEV*DATA_LEN-1:0]   dev_data_in,
  output logic [N_DEV-1:0]            dev_grant,
  output logic [N_DEV-1:0]            dev_dma_ack,
  output logic [N_DEV-1:0]            dev_end,
  output logic [N_DEV-1:0]            dev_err,
  output logic [DATA_LEN-1:0]         dev_data_out,
  output logic                        busy,
  output state_t                      dbg_state,
  dma_channel_arbiter_if.master       dma
);

  localparam int IDX_W = $clog2(N_DEV);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] owner, last_owner, pick_idx;
  logic [N_DEV-1:0] owner_oh, pick_oh;
  logic             pick_valid;
  logic [TO_W-1:0]  wd_cnt;
  logic             wd_expire;
  logic             abort_second;

  dma_channel_arbiter_rr_picker #(
    .N_DEV (N_DEV),
    .IDX_W (IDX_W)
  ) u_picker (
    .req        (dev_rqst),
    .last_owner (last_owner),
    .grant      (pick_oh),
    .idx        (pick_idx),
    .valid      (pick_valid)
  );

  always_comb wd_expire = (TIMEOUT != 0) && (wd_cnt == TO_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // End of transfer takes precedence over a watchdog expiry in the same cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (pick_valid) state_nxt = ST_ISSUE;
      ST_ISSUE:   state_nxt = ST_BUSY;
      ST_BUSY: begin
        if (dma.dma_end_flag) state_nxt = ST_RELEASE;
        else if (wd_expire)   state_nxt = ST_ABORT;
      end
      ST_ABORT:   if (abort_second) state_nxt = ST_RELEASE;
      ST_RELEASE: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner        <= '0;
      owner_oh     <= '0;
      last_owner   <= IDX_W'(N_DEV - 1);
      wd_cnt       <= '0;
      abort_second <= 1'b0;
    end else begin
      if (state == ST_IDLE && pick_valid) begin
        owner    <= pick_idx;
        owner_oh <= pick_oh;
      end
      if (state == ST_RELEASE) last_owner <= owner;
      abort_second <= (state == ST_ABORT) && !abort_second;
      if (TIMEOUT == 0 || state == ST_ISSUE)
        wd_cnt <= '0;
      else if (state == ST_BUSY && wd_cnt != '1)
        wd_cnt <= wd_cnt + TO_W'(1);
    end
  end

  always_comb begin
    dev_grant          = '0;
    dev_end            = '0;
    dev_err            = '0;
    dma.dma_rqst       = 1'b0;
    dma.dma_rd_wr      = 1'b0;
    dma.dma_num_words  = '0;
    dma.dma_start_addr = '0;
    dma.dma_dev_ack    = 1'b0;
    dma.dma_dev_in     = '0;
    dma.dma_rst        = 1'b0;
    if (holds_bus(state) || state == ST_ABORT) dev_grant = owner_oh;
    if (holds_bus(state)) begin
      dma.dma_rqst       = 1'b1;
      dma.dma_rd_wr      = dev_rd_wr[owner];
      dma.dma_num_words  = dev_num_words[int'(owner)*ADD_LEN +: ADD_LEN];
      dma.dma_start_addr = dev_start_addr[int'(owner)*(ADD_LEN+1) +: (ADD_LEN+1)];
      dma.dma_dev_ack    = dev_ack_in[owner];
      dma.dma_dev_in     = dev_data_in[int'(owner)*DATA_LEN +: DATA_LEN];
    end
    if (state == ST_BUSY && dma.dma_end_flag) dev_end = owner_oh;
    if (state == ST_ABORT) begin
      dma.dma_rst = 1'b1;
      if (!abort_second) begin
        dev_end = owner_oh;
        dev_err = owner_oh;
      end
    end
  end

  assign dev_dma_ack  = dev_grant & {N_DEV{dma.dma_ack_in}};
  assign dev_data_out = dma.dma_dev_out;
  assign busy         = (state != ST_IDLE);
  assign dbg_state    = state;

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// Directed bench for dma_channel_arbiter: a vector table of single transfers
// plus hand-written sequences for rotation, steering, watchdog and reset.
module tb_dma_channel_arbiter;
  import dma_channel_arbiter_pkg::*;

  localparam int N_DEV    = 4;
  localparam int ADD_LEN  = 16;
  localparam int DATA_LEN = 16;
  localparam int TIMEOUT  = 16;
  localparam int TO_W     = 5;

  logic                         clk = 1'b0;
  logic                         reset;
  logic [N_DEV-1:0]             dev_rqst, dev_rd_wr, dev_ack_in;
  logic [N_DEV*ADD_LEN-1:0]     dev_num_words;
  logic [N_DEV*(ADD_LEN+1)-1:0] dev_start_addr;
  logic [N_DEV*DATA_LEN-1:0]    dev_data_in;
  logic [N_DEV-1:0]             dev_grant, dev_dma_ack, dev_end, dev_err;
  logic [DATA_LEN-1:0]          dev_data_out;
  logic                         busy;
  state_t                       dbg_state;

  dma_channel_arbiter_if #(.ADD_LEN(ADD_LEN), .DATA_LEN(DATA_LEN)) dma_bus ();

  dma_channel_arbiter #(
    .N_DEV(N_DEV), .ADD_LEN(ADD_LEN), .DATA_LEN(DATA_LEN),
    .TIMEOUT(TIMEOUT), .TO_W(TO_W)
  ) dut (
    .clk(clk), .reset(reset),
    .dev_rqst(dev_rqst), .dev_rd_wr(dev_rd_wr), .dev_num_words(dev_num_words),
    .dev_start_addr(dev_start_addr), .dev_ack_in(dev_ack_in), .dev_data_in(dev_data_in),
    .dev_grant(dev_grant), .dev_dma_ack(dev_dma_ack), .dev_end(dev_end), .dev_err(dev_err),
    .dev_data_out(dev_data_out), .busy(busy), .dbg_state(dbg_state), .dma(dma_bus)
  );

  // Clock and global time limit
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL sim_timeout: got running, want finished");
    $fatal(1, "simulation time limit reached");
  end

  typedef struct {
    logic [3:0]  rqst;
    logic [3:0]  grant;
    logic [15:0] words;
    logic [16:0] addr;
    logic        rd_wr;
    logic [15:0] data;
    int          busy_cycles;
  } vec_t;

  vec_t       vecs[8];
  vec_t       cur;
  logic [3:0] exp_q[$];
  logic [3:0] exp_oh;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         n_wait;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_defaults();
    dev_rqst                = '0;
    dev_ack_in              = '0;
    dev_rd_wr               = 4'b0101;
    dev_num_words           = {16'd5, 16'd4, 16'd3, 16'd2};
    dev_start_addr          = {17'h04000, 17'h03000, 17'h02000, 17'h01000};
    dev_data_in             = {16'hA0A3, 16'hA0A2, 16'hA0A1, 16'hA0A0};
    dma_bus.dma_ack_in      = 1'b0;
    dma_bus.dma_end_flag    = 1'b0;
    dma_bus.dma_dev_out     = '0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    drive_defaults();
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_grant"}, {dev_grant, dev_dma_ack, dev_end, dev_err}, 16'h0);
    check({tag, "_ctrl"}, {dma_bus.dma_rqst, dma_bus.dma_rst, busy, dma_bus.dma_rd_wr, dma_bus.dma_dev_ack}, 5'b0);
    check({tag, "_fields"}, {dma_bus.dma_num_words, dma_bus.dma_start_addr, dma_bus.dma_dev_in}, 49'h0);
    check({tag, "_state"}, dbg_state, ST_IDLE);
  endtask

  initial begin
    vecs[0] = '{4'b0100, 4'b0100, 16'd4, 17'h03000, 1'b1, 16'hA0A2, 2};
    vecs[1] = '{4'b1111, 4'b1000, 16'd5, 17'h04000, 1'b0, 16'hA0A3, 1};
    vecs[2] = '{4'b1111, 4'b0001, 16'd2, 17'h01000, 1'b1, 16'hA0A0, 3};
    vecs[3] = '{4'b0011, 4'b0010, 16'd3, 17'h02000, 1'b0, 16'hA0A1, 4};
    vecs[4] = '{4'b0011, 4'b0001, 16'd2, 17'h01000, 1'b1, 16'hA0A0, 1};
    vecs[5] = '{4'b1010, 4'b0010, 16'd3, 17'h02000, 1'b0, 16'hA0A1, 5};
    vecs[6] = '{4'b1010, 4'b1000, 16'd5, 17'h04000, 1'b0, 16'hA0A3, 2};
    vecs[7] = '{4'b0001, 4'b0001, 16'd2, 17'h01000, 1'b1, 16'hA0A0, 1};

    apply_reset();
    #2;
    check_idle_outputs("reset");

    // Table: one transfer per record, rotation carried across records
    for (int v = 0; v < 8; v++) begin
      cur = vecs[v];
      tick(); dev_rqst = cur.rqst; #2;
      tick(); dev_rqst = '0; #2;
      check("vec_state_issue", dbg_state, ST_ISSUE);
      check("vec_grant", dev_grant, cur.grant);
      check("vec_rqst_busy", {dma_bus.dma_rqst, busy}, 2'b11);
      check("vec_words", dma_bus.dma_num_words, cur.words);
      check("vec_addr", dma_bus.dma_start_addr, cur.addr);
      check("vec_rd_wr", dma_bus.dma_rd_wr, cur.rd_wr);
      check("vec_data", dma_bus.dma_dev_in, cur.data);
      for (int b = 1; b <= cur.busy_cycles; b++) begin
        tick(); dma_bus.dma_end_flag = (b == cur.busy_cycles); #2;
      end
      check("vec_end", dev_end, cur.grant);
      check("vec_err", dev_err, 4'b0);
      tick(); dma_bus.dma_end_flag = 1'b0; #2;
      check("vec_release", {dbg_state, dev_grant, dma_bus.dma_rqst, busy}, {ST_RELEASE, 4'b0, 1'b0, 1'b1});
      check("vec_release_words", dma_bus.dma_num_words, 16'd0);
      tick(); #2;
      check("vec_idle_busy", busy, 1'b0);
    end

    // All four requesting continuously after reset: strict rotation, 3-cycle gap
    apply_reset();
    for (int r = 0; r < 3; r++)
      for (int d = 0; d < 4; d++) exp_q.push_back(4'b0001 << d);
    dev_rqst = 4'b1111;
    for (int t = 0; t < 12; t++) begin
      n_wait = 0;
      do begin
        tick(); dma_bus.dma_end_flag = 1'b0; #2;
        n_wait++;
      end while (dbg_state != ST_ISSUE && n_wait < 20);
      check("rr_issue_seen", dbg_state, ST_ISSUE);
      if (t > 0) check("rr_gap", n_wait, 3);
      exp_oh = exp_q.pop_front();
      check("rr_grant", dev_grant, exp_oh);
      tick(); #2;
      tick(); dma_bus.dma_end_flag = 1'b1; #2;
      check("rr_end", dev_end, exp_oh);
    end
    check("rr_queue_drained", exp_q.size(), 0);
    dev_rqst = '0;
    tick(); dma_bus.dma_end_flag = 1'b0; #2;
    tick(); #2;
    check("rr_idle", dbg_state, ST_IDLE);

    // Owner 1: ack routing, data steering, ignored end flags and request drop
    tick(); dma_bus.dma_end_flag = 1'b1; #2;
    check("idle_end_ignored", dev_end, 4'b0);
    tick(); dma_bus.dma_end_flag = 1'b0; dev_rqst = 4'b0010; #2;
    check("idle_stays", dbg_state, ST_IDLE);
    tick(); dev_rqst = '0; dma_bus.dma_end_flag = 1'b1; #2;
    check("own1_grant", dev_grant, 4'b0010);
    check("issue_end_ignored", dev_end, 4'b0);
    tick(); dma_bus.dma_end_flag = 1'b0; dev_ack_in = 4'b0010; dma_bus.dma_ack_in = 1'b1; #2;
    check("own1_busy", dbg_state, ST_BUSY);
    check("own1_ack_route", dev_dma_ack, 4'b0010);
    check("own1_dev_ack", dma_bus.dma_dev_ack, 1'b1);
    check("own1_data", dma_bus.dma_dev_in, 16'hA0A1);
    dma_bus.dma_ack_in = 1'b0;
    dev_ack_in = 4'b1001;
    dev_data_in = {16'h1111, 16'hA0A2, 16'hA0A1, 16'h2222};
    #2;
    check("own1_ack_low", dev_dma_ack, 4'b0);
    check("own1_dev_ack_low", dma_bus.dma_dev_ack, 1'b0);
    check("own1_data_held", dma_bus.dma_dev_in, 16'hA0A1);
    dma_bus.dma_dev_out = 16'h5A5A;
    #1;
    check("read_broadcast", dev_data_out, 16'h5A5A);
    tick(); #2;
    check("own1_still_busy", dbg_state, ST_BUSY);
    tick(); dma_bus.dma_end_flag = 1'b1; #2;
    check("own1_end", dev_end, 4'b0010);
    tick(); dma_bus.dma_end_flag = 1'b0; drive_defaults(); #2;
    check("own1_release_data", {dma_bus.dma_dev_in, dma_bus.dma_dev_ack}, 17'h0);
    tick(); #2;

    // Watchdog abort of device 2, then device 3 is granted
    tick(); dev_rqst = 4'b1100; #2;
    tick(); #2;
    check("wd_grant", dev_grant, 4'b0100);
    for (int b = 1; b <= 16; b++) begin
      tick(); #2;
    end
    check("wd_busy16", dbg_state, ST_BUSY);
    tick(); #2;
    check("wd_abort1_state", dbg_state, ST_ABORT);
    check("wd_abort1_rst", {dma_bus.dma_rst, dma_bus.dma_rqst}, 2'b10);
    check("wd_abort1_pulses", {dev_err, dev_end, dev_grant}, {4'b0100, 4'b0100, 4'b0100});
    tick(); #2;
    check("wd_abort2_state", dbg_state, ST_ABORT);
    check("wd_abort2_rst", dma_bus.dma_rst, 1'b1);
    check("wd_abort2_pulses", {dev_err, dev_end}, 8'h0);
    tick(); #2;
    check("wd_release", {dbg_state, dma_bus.dma_rst, dev_grant}, {ST_RELEASE, 1'b0, 4'b0});
    tick(); #2;
    tick(); dev_rqst = '0; #2;
    check("wd_next_grant", dev_grant, 4'b1000);

    // End flag on the same cycle the watchdog would expire
    for (int b = 1; b <= 15; b++) begin
      tick(); #2;
    end
    tick(); dma_bus.dma_end_flag = 1'b1; #2;
    check("coinc_end", dev_end, 4'b1000);
    check("coinc_no_err", {dev_err, dma_bus.dma_rst}, 5'b0);
    tick(); dma_bus.dma_end_flag = 1'b0; #2;
    check("coinc_release", {dbg_state, dma_bus.dma_rst}, {ST_RELEASE, 1'b0});
    tick(); #2;

    // Asynchronous reset in BUSY, then device 0 wins a 0/3 tie
    tick(); dev_rqst = 4'b0001; #2;
    tick(); dev_rqst = '0; #2;
    tick(); #2;
    check("rst_pre_busy", dbg_state, ST_BUSY);
    reset = 1'b1;
    #1;
    check_idle_outputs("rst_async");
    tick(); tick(); reset = 1'b0; dev_rqst = 4'b1001; #2;
    tick(); #2;
    check("rst_tie_state", dbg_state, ST_ISSUE);
    check("rst_tie_grant", dev_grant, 4'b0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
